// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared flag layout and limits for the control-bundle pipeline chain.
package ctrl_pipe_pkg;
   typedef struct packed {
      logic force_jump;
      logic branch;
      logic mem_write;
      logic mem_read;
   } ctrl_flags_t;
   localparam int FLAG_FORCE_JUMP = 3;
   localparam int FLAG_BRANCH     = 2;
   localparam int FLAG_MEM_WRITE  = 1;
   localparam int FLAG_MEM_READ   = 0;
   localparam int MAX_STAGES      = 4;
endpackage

// File: rtl/ctrl_pipe_slot.sv
// ctrl_pipe_slot: one pipeline register stage; flush beats hold, and any non-loaded slot is zeroed.
module ctrl_pipe_slot #(
   parameter int W = 41
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         flush,
   input  logic         hold,
   input  logic         load_valid,
   input  logic [W-1:0] load_bundle,
   output logic         valid,
   output logic [W-1:0] bundle
);
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         valid  <= 1'b0;
         bundle <= '0;
      end else if (flush) begin
         valid  <= 1'b0;
         bundle <= '0;
      end else if (!hold) begin
         valid  <= load_valid;
         bundle <= load_valid ? load_bundle : '0;
      end
endmodule

// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: STAGES-deep control-bundle pipeline with bubble-collapsing hold chain.
// Optional saturating perf counters are built when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe_chain
   import ctrl_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int FUNC_W = 5,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_jump_pc,
   input  logic [FUNC_W-1:0]        in_func,
   input  logic [3:0]               in_flags,
   input  logic [STAGES-1:0]        stall,
   input  logic [STAGES-1:0]        flush,
   output logic [STAGES-1:0]        st_valid,
   output logic [STAGES*XLEN-1:0]   st_jump_pc,
   output logic [STAGES*FUNC_W-1:0] st_func,
   output logic [STAGES*4-1:0]      st_flags,
   output logic [CNT_W-1:0]         perf_stall_cnt,
   output logic [CNT_W-1:0]         perf_bubble_cnt
);
   localparam int BW = XLEN + FUNC_W + 4;
   logic [STAGES:0] hold;
   logic [STAGES-1:0][BW-1:0] bun;
   ctrl_flags_t in_fl;
   assign in_fl = in_flags;
   assign hold[STAGES] = 1'b0;
   assign in_ready = ~hold[0];
   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_st
      logic          lv;
      logic [BW-1:0] lb;
      // an empty stage never holds, so bubbles are squeezed out
      assign hold[k] = st_valid[k] & (stall[k] | hold[k+1]);
      if (k == 0) begin : g_src_in
         assign lv = in_valid;
         assign lb = {in_jump_pc, in_func, in_fl};
      end else begin : g_src_st
         assign lv = st_valid[k-1] & ~hold[k-1];
         assign lb = bun[k-1];
      end
      ctrl_pipe_slot #(.W(BW)) u_slot (
         .CLK        (CLK),
         .RESET_N    (RESET_N),
         .flush      (flush[k]),
         .hold       (hold[k]),
         .load_valid (lv),
         .load_bundle(lb),
         .valid      (st_valid[k]),
         .bundle     (bun[k])
      );
      assign st_jump_pc[k*XLEN +: XLEN]   = bun[k][BW-1 -: XLEN];
      assign st_func[k*FUNC_W +: FUNC_W]  = bun[k][4 +: FUNC_W];
      assign st_flags[k*4 +: 4]           = bun[k][3:0];
   end
`ifdef CTRL_PIPE_PERF_EN
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         perf_stall_cnt  <= '0;
         perf_bubble_cnt <= '0;
      end else begin
         if (in_valid && !in_ready && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
         if (!st_valid[STAGES-1] && !(&perf_bubble_cnt)) perf_bubble_cnt <= perf_bubble_cnt + CNT_W'(1);
      end
`else
   assign perf_stall_cnt  = '0;
   assign perf_bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain: table-driven check of the 2-stage chain plus reset and counter sequences.
module tb_ctrl_pipe_chain;
   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_jump_pc;
   logic [4:0]  in_func;
   logic [3:0]  in_flags;
   logic [1:0]  stall, flush;
   logic [1:0]  st_valid;
   logic [63:0] st_jump_pc;
   logic [9:0]  st_func;
   logic [7:0]  st_flags;
   logic [3:0]  perf_stall_cnt, perf_bubble_cnt;
   int total = 0;
   int bad = 0;
   always #5 CLK = ~CLK;
   ctrl_pipe_chain #(.XLEN(32), .FUNC_W(5), .STAGES(2), .CNT_W(4)) dut (
      .CLK            (CLK),
      .RESET_N        (RESET_N),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_jump_pc     (in_jump_pc),
      .in_func        (in_func),
      .in_flags       (in_flags),
      .stall          (stall),
      .flush          (flush),
      .st_valid       (st_valid),
      .st_jump_pc     (st_jump_pc),
      .st_func        (st_func),
      .st_flags       (st_flags),
      .perf_stall_cnt (perf_stall_cnt),
      .perf_bubble_cnt(perf_bubble_cnt)
   );
   typedef struct {
      logic        v;
      logic [40:0] in;
      logic [1:0]  stall;
      logic [1:0]  flush;
      logic        rdy;
      logic [40:0] e0;
      logic [40:0] e1;
   } vec_t;
   vec_t vt[17];
   function automatic logic [40:0] b(input logic [31:0] pc, input logic [4:0] fn, input logic [3:0] fl);
      return {pc, fn, fl};
   endfunction
   function automatic vec_t mk(input logic v, input logic [40:0] in, input logic [1:0] s, input logic [1:0] f,
                               input logic rdy, input logic [40:0] e0, input logic [40:0] e1);
      vec_t r;
      r.v = v; r.in = in; r.stall = s; r.flush = f; r.rdy = rdy; r.e0 = e0; r.e1 = e1;
      return r;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [41:0] stage(input int k);
      return {st_valid[k], st_jump_pc[k*32 +: 32], st_func[k*5 +: 5], st_flags[k*4 +: 4]};
   endfunction
   initial begin
      logic [40:0] z, b100, b104, b108, b200, b204, b208, b20c, b300, b304;
      z = '0;
      b100 = b(32'h100, 5'd1, 4'h1); b104 = b(32'h104, 5'd2, 4'h2); b108 = b(32'h108, 5'd3, 4'h8);
      b200 = b(32'h200, 5'd4, 4'h4); b204 = b(32'h204, 5'd5, 4'h2); b208 = b(32'h208, 5'd6, 4'h1);
      b20c = b(32'h20c, 5'd7, 4'h3); b300 = b(32'h300, 5'd8, 4'h4); b304 = b(32'h304, 5'd9, 4'h8);
      vt[0]  = mk(1, b100, 2'b00, 2'b00, 1, b100, z);
      vt[1]  = mk(1, b104, 2'b00, 2'b00, 1, b104, b100);
      vt[2]  = mk(1, b108, 2'b00, 2'b00, 1, b108, b104);
      vt[3]  = mk(0, z,    2'b00, 2'b00, 1, z,    b108);
      vt[4]  = mk(0, z,    2'b00, 2'b00, 1, z,    z);
      vt[5]  = mk(1, b200, 2'b00, 2'b00, 1, b200, z);
      vt[6]  = mk(0, z,    2'b00, 2'b00, 1, z,    b200);
      vt[7]  = mk(1, b204, 2'b10, 2'b00, 1, b204, b200);
      vt[8]  = mk(1, b208, 2'b10, 2'b00, 0, b204, b200);
      vt[9]  = mk(1, b208, 2'b10, 2'b10, 0, b204, z);
      vt[10] = mk(1, b208, 2'b10, 2'b00, 1, b208, b204);
      vt[11] = mk(1, b20c, 2'b00, 2'b01, 1, z,    b208);
      vt[12] = mk(0, z,    2'b00, 2'b00, 1, z,    z);
      vt[13] = mk(1, b300, 2'b00, 2'b00, 1, b300, z);
      vt[14] = mk(1, b304, 2'b01, 2'b00, 0, b300, z);
      vt[15] = mk(1, b304, 2'b00, 2'b00, 1, b304, b300);
      vt[16] = mk(0, z,    2'b00, 2'b00, 1, z,    b304);
      RESET_N = 1'b0; in_valid = 1'b0; in_jump_pc = '0; in_func = '0; in_flags = '0; stall = '0; flush = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_valid", 64'(st_valid), 64'd0);
      chk("reset_bundle", {st_jump_pc}, 64'd0);
      chk("reset_ff", 64'({st_func, st_flags}), 64'd0);
      chk("reset_ready", 64'(in_ready), 64'd1);
      chk("reset_perf", 64'({perf_stall_cnt, perf_bubble_cnt}), 64'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      for (int i = 0; i < 17; i++) begin
         @(negedge CLK);
         in_valid = vt[i].v;
         {in_jump_pc, in_func, in_flags} = vt[i].in;
         stall = vt[i].stall;
         flush = vt[i].flush;
         #1;
         chk($sformatf("ready[%0d]", i), 64'(in_ready), 64'(vt[i].rdy));
         @(posedge CLK);
         #1;
         chk($sformatf("s0[%0d]", i), 64'(stage(0)), 64'({|vt[i].e0, vt[i].e0}));
         chk($sformatf("s1[%0d]", i), 64'(stage(1)), 64'({|vt[i].e1, vt[i].e1}));
      end
`ifdef CTRL_PIPE_PERF_EN
      chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
`else
      chk("perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
      @(negedge CLK);
      in_valid = 1'b1; stall = '0; flush = '0;
      {in_jump_pc, in_func, in_flags} = b(32'h400, 5'd10, 4'h2);
      @(negedge CLK);
      {in_jump_pc, in_func, in_flags} = b(32'h404, 5'd11, 4'h2);
      @(posedge CLK);
      #1;
      chk("mid_both_valid", 64'({st_valid, st_flags}), 64'({2'b11, 8'h22}));
      in_valid = 1'b0;
      RESET_N = 1'b0;
      #1;
      chk("async_valid", 64'(st_valid), 64'd0);
      chk("async_pc", st_jump_pc, 64'd0);
      chk("async_ff", 64'({st_func, st_flags}), 64'd0);
      chk("async_perf", 64'({perf_stall_cnt, perf_bubble_cnt}), 64'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (20) @(posedge CLK);
      #1;
`ifdef CTRL_PIPE_PERF_EN
      chk("bubble_sat", 64'(perf_bubble_cnt), 64'd15);
`else
      chk("bubble_sat", 64'(perf_bubble_cnt), 64'd0);
`endif
      repeat (3) @(posedge CLK);
      #1;
`ifdef CTRL_PIPE_PERF_EN
      chk("bubble_hold", 64'(perf_bubble_cnt), 64'd15);
`else
      chk("bubble_hold", 64'(perf_bubble_cnt), 64'd0);
`endif
      chk("idle_stall_cnt", 64'(perf_stall_cnt), 64'd0);
      chk("idle_ready", 64'(in_ready), 64'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
